// File: rtl/fp16_mac_pkg.sv
// Shared definitions for the FP16 multiply-accumulate control path.
//   FP16_ONE / FP16_ZERO : encodings used by the sequencer to build issue slots
//   MAC_PIPE_LAT         : operand-register to accumulator-output latency of the MAC
//   seq_state_t          : sequencer FSM state encoding
//   fp16_neg()           : sign flip (exact for every encoding, NaN included)
package fp16_mac_pkg;

  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  // Cycles from a registered operand pair to its product landing in mac_acc.
  localparam int MAC_PIPE_LAT = 3;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    CLR,
    CLR_DRAIN,
    ISSUE,
    DRAIN,
    CAPTURE
  } seq_state_t;

  function automatic logic [15:0] fp16_neg(input logic [15:0] x);
    return {~x[15], x[14:0]};
  endfunction

endpackage

// File: rtl/fp16_dot_sequencer_if.sv
// Host-side bundle of the dot-product sequencer: vector start request,
// operand-pair stream (valid/ready) and the per-vector result.
//   master : host driving start/vec_len/operands, observing ready/busy/result
//   slave  : the sequencer
interface fp16_dot_sequencer_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] vec_len;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic             busy;
  logic             res_valid;
  logic [15:0]      res_data;

  modport master (
    output start, vec_len, in_valid, in_a, in_b,
    input  in_ready, busy, res_valid, res_data
  );

  modport slave (
    input  start, vec_len, in_valid, in_a, in_b,
    output in_ready, busy, res_valid, res_data
  );
endinterface

// File: rtl/mac_kill_delay.sv
// Delay line for the per-slot kill flag. The MAC gates the product at its
// second pipeline register, so the kill must trail the operands by DLY cycles.
//   clk, rst  : clock, asynchronous active-high reset
//   kill_in   : kill flag of the slot being issued this cycle
//   kill_out  : mac_stop, kill_in delayed by DLY cycles
module mac_kill_delay #(
  parameter int DLY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic kill_in,
  output logic kill_out
);

  logic [DLY-1:0] sr;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Reset to all ones: anything still inside the MAC pipeline is killed.
      sr <= '1;
    end else begin
      sr[0] <= kill_in;
      for (int i = 1; i < DLY; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign kill_out = sr[DLY-1];

endmodule

// File: rtl/fp16_dot_sequencer.sv
// Control stage in front of the FP16 MAC. For each vector it flushes the MAC,
// cancels the (unresettable) accumulator with acc + (-acc)*1.0, streams the
// operand pairs, waits for the pipeline to drain and captures the result.
//   clk, rst           : clock, asynchronous active-high reset
//   host (slave)       : start/vec_len, in_valid/in_ready/in_a/in_b, busy,
//                        res_valid/res_data
//   mac_num_a/mac_num_b: registered operands to the MAC
//   mac_stop           : product kill, STOP_DLY cycles behind its operands
//   mac_acc            : accumulator output from the MAC
module fp16_dot_sequencer
  import fp16_mac_pkg::*;
#(
  parameter int LEN_W     = 8,
  parameter int STOP_DLY  = 2,
  parameter int DRAIN_CYC = MAC_PIPE_LAT + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  fp16_dot_sequencer_if.slave   host,
  output logic [15:0]           mac_num_a,
  output logic [15:0]           mac_num_b,
  output logic                  mac_stop,
  input  logic [15:0]           mac_acc
);

  localparam int              CNT_W    = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYC - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] dly_cnt;
  logic [LEN_W-1:0] rem_cnt;
  logic             dly_done;
  logic             hs;
  logic [15:0]      slot_a;
  logic [15:0]      slot_b;
  logic             slot_kill;
  logic             res_valid_q;
  logic [15:0]      res_data_q;

  assign host.in_ready  = (state == ISSUE);
  assign host.busy      = (state != IDLE);
  assign host.res_valid = res_valid_q;
  assign host.res_data  = res_data_q;

  assign hs       = (state == ISSUE) && host.in_valid;
  assign dly_done = (dly_cnt == CNT_LAST);

  // Issue slot for this cycle: bubble unless clearing or accepting a pair.
  // NOTE: every output gets a default before the conditionals so the block
  // stays purely combinational (no latch on any path).
  always_comb begin
    slot_a    = FP16_ZERO;
    slot_b    = FP16_ZERO;
    slot_kill = 1'b1;
    if (state == CLR) begin
      // -acc * 1.0 added to acc gives +0 exactly; a NaN accumulator stays NaN.
      slot_a    = fp16_neg(mac_acc);
      slot_b    = FP16_ONE;
      slot_kill = 1'b0;
    end else if (hs) begin
      slot_a    = host.in_a;
      slot_b    = host.in_b;
      slot_kill = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_num_a <= FP16_ZERO;
      mac_num_b <= FP16_ZERO;
    end else begin
      mac_num_a <= slot_a;
      mac_num_b <= slot_b;
    end
  end

  mac_kill_delay #(
    .DLY (STOP_DLY)
  ) u_kill_delay (
    .clk      (clk),
    .rst      (rst),
    .kill_in  (slot_kill),
    .kill_out (mac_stop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dly_cnt     <= '0;
      rem_cnt     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= FP16_ZERO;
    end else begin
      res_valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (host.start) begin
            rem_cnt <= host.vec_len;
            dly_cnt <= '0;
            state   <= FLUSH;
          end
        end
        FLUSH: begin
          if (dly_done) begin
            dly_cnt <= '0;
            state   <= CLR;
          end else begin
            dly_cnt <= dly_cnt + CNT_W'(1);
          end
        end
        CLR: begin
          dly_cnt <= '0;
          state   <= CLR_DRAIN;
        end
        CLR_DRAIN: begin
          if (dly_done) begin
            dly_cnt <= '0;
            state   <= (rem_cnt == '0) ? CAPTURE : ISSUE;
          end else begin
            dly_cnt <= dly_cnt + CNT_W'(1);
          end
        end
        ISSUE: begin
          if (hs) begin
            rem_cnt <= rem_cnt - LEN_W'(1);
            if (rem_cnt == LEN_W'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (dly_done) begin
            dly_cnt <= '0;
            state   <= CAPTURE;
          end else begin
            dly_cnt <= dly_cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          res_data_q  <= mac_acc;
          res_valid_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_dot_sequencer.sv
// Directed bench for fp16_dot_sequencer, wired to a behavioural model of the
// FP16 MAC (operand register, product register gated by mac_stop, accumulator
// with no reset and a non-zero power-up value).
module tb_fp16_dot_sequencer;

  localparam int STOP_DLY  = 2;
  localparam int DRAIN_CYC = 4;
  localparam int HIST      = 128;
  localparam int MAX_CYC   = 100;

  logic        clk;
  logic        rst;
  logic [15:0] mac_num_a;
  logic [15:0] mac_num_b;
  logic        mac_stop;
  logic [15:0] mac_acc;

  int n_vec = 0;
  int n_err = 0;

  int   slot_kind [0:HIST-1];
  logic stop_hist [0:HIST-1];

  fp16_dot_sequencer_if #(.LEN_W(8)) host ();

  fp16_dot_sequencer #(
    .LEN_W     (8),
    .STOP_DLY  (STOP_DLY),
    .DRAIN_CYC (DRAIN_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host),
    .mac_num_a (mac_num_a),
    .mac_num_b (mac_num_b),
    .mac_stop  (mac_stop),
    .mac_acc   (mac_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FP16 helpers (exact for the values used here) --------
  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) m = real'(h[9:0]) * (2.0 ** (-24));
    else        m = (1.0 + real'(h[9:0]) / 1024.0) * (2.0 ** (e - 15));
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    int   e;
    int   m;
    real  x;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    x = s ? -r : r;
    e = 0;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0)  begin x = x * 2.0; e--; end
    m = int'((x - 1.0) * 1024.0);
    if (m == 1024) begin m = 0; e++; end
    return {s, 5'(e + 15), 10'(m)};
  endfunction

  // ---------------- MAC model --------------------------------------------
  logic [15:0] s1_a  = 16'h0000;
  logic [15:0] s1_b  = 16'h0000;
  logic [15:0] s2_p  = 16'h0000;
  logic [15:0] acc_q = 16'h4500;  // power-up garbage (5.0)

  always @(posedge clk) begin
    s1_a  <= mac_num_a;
    s1_b  <= mac_num_b;
    s2_p  <= mac_stop ? 16'h0000 : r2h(h2r(s1_a) * h2r(s1_b));
    acc_q <= r2h(h2r(acc_q) + h2r(s2_p));
  end
  assign mac_acc = acc_q;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic log_stop(input int cyc);
    if (cyc < HIST) stop_hist[cyc] = mac_stop;
  endtask

  // Runs one vector; returns the first captured result, its latency from the
  // last handshake edge, the res_valid pulse count and the in_ready cycles.
  task automatic run_vec(input int len, input logic [15:0] a [0:3],
                         input logic [15:0] b [0:3], input int gap,
                         input bit poke, output logic [15:0] res,
                         output int lat, output int pulses,
                         output int ready_seen, output bit tmo);
    int cyc, idx, gapcnt, last;
    bit hs;
    cyc = 0; idx = 0; gapcnt = 0; pulses = 0; ready_seen = 0; tmo = 1'b0;
    res = 'x; lat = -1;
    for (int i = 0; i < HIST; i++) begin
      slot_kind[i] = -1;
      stop_hist[i] = 1'b0;
    end
    log_stop(0);
    host.start   = 1'b1;
    host.vec_len = len[7:0];
    tick();
    host.start = 1'b0;
    cyc  = 1;
    last = 1;
    while (idx < len && !tmo) begin
      log_stop(cyc);
      host.start    = poke && (cyc == 3);
      if (host.in_ready) ready_seen++;
      host.in_valid = (gapcnt == 0);
      host.in_a     = a[idx];
      host.in_b     = b[idx];
      hs = host.in_valid && host.in_ready;
      if (host.in_ready && cyc < HIST) slot_kind[cyc] = hs ? 0 : 1;
      if (!hs && host.in_ready && gapcnt > 0) gapcnt--;
      tick();
      cyc++;
      if (hs) begin
        idx++;
        last = cyc;
        gapcnt = gap;
      end
      if (cyc > MAX_CYC) tmo = 1'b1;
    end
    host.in_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      log_stop(cyc);
      if (host.in_ready) ready_seen++;
      if (host.res_valid) begin
        pulses++;
        if (pulses == 1) begin
          res = host.res_data;
          lat = cyc - last;
        end
      end
      host.start = poke && (len > 0) && (cyc == last + DRAIN_CYC);
      tick();
      cyc++;
    end
    host.start = 1'b0;
  endtask

  // ---------------- tests -------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_vec++; if (mac_stop !== 1'b1) begin n_err++; $display("FAIL rst_mac_stop: got %b want 1", mac_stop); end
    n_vec++; if (mac_num_a !== 16'h0000 || mac_num_b !== 16'h0000) begin n_err++; $display("FAIL rst_mac_num: got %h/%h want 0000/0000", mac_num_a, mac_num_b); end
    n_vec++; if (host.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", host.busy); end
    n_vec++; if (host.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", host.in_ready); end
    n_vec++; if (host.res_valid !== 1'b0 || host.res_data !== 16'h0000) begin n_err++; $display("FAIL rst_result: got %b/%h want 0/0000", host.res_valid, host.res_data); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [0:3];
    logic [15:0] vb [0:3];
    logic [15:0] res;
    int lat, pulses, rdy;
    bit tmo;
    va = '{16'h3C00, 16'h4200, 16'h0000, 16'h0000};
    vb = '{16'h4000, 16'h3800, 16'h0000, 16'h0000};
    run_vec(2, va, vb, 0, 1'b0, res, lat, pulses, rdy, tmo);
    n_vec++; if (tmo) begin n_err++; $display("FAIL b2b_timeout: got timeout want 2 handshakes"); end
    n_vec++; if (res !== 16'h4300) begin n_err++; $display("FAIL b2b_res: got %h want 4300", res); end
    n_vec++; if (lat !== DRAIN_CYC + 1) begin n_err++; $display("FAIL b2b_latency: got %0d want %0d", lat, DRAIN_CYC + 1); end
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL b2b_pulses: got %0d want 1", pulses); end
    n_vec++; if (rdy !== 2) begin n_err++; $display("FAIL b2b_ready_cycles: got %0d want 2", rdy); end
  endtask

  task automatic test_consecutive();
    logic [15:0] va [0:3];
    logic [15:0] vb [0:3];
    logic [15:0] res;
    int lat, pulses, rdy;
    bit tmo;
    va = '{16'h3C00, 16'h4200, 16'h0000, 16'h0000};
    vb = '{16'h4000, 16'h3800, 16'h0000, 16'h0000};
    run_vec(2, va, vb, 0, 1'b0, res, lat, pulses, rdy, tmo);
    n_vec++; if (res !== 16'h4300) begin n_err++; $display("FAIL consec_first_res: got %h want 4300", res); end
    va = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
    vb = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
    run_vec(1, va, vb, 0, 1'b0, res, lat, pulses, rdy, tmo);
    n_vec++; if (res !== 16'h4400) begin n_err++; $display("FAIL consec_second_res: got %h want 4400", res); end
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL consec_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_gaps();
    logic [15:0] va [0:3];
    logic [15:0] vb [0:3];
    logic [15:0] res;
    int lat, pulses, rdy, nbub;
    bit tmo;
    va = '{16'h3C00, 16'h4200, 16'h0000, 16'h0000};
    vb = '{16'h4000, 16'h3800, 16'h0000, 16'h0000};
    run_vec(2, va, vb, 3, 1'b0, res, lat, pulses, rdy, tmo);
    n_vec++; if (res !== 16'h4300) begin n_err++; $display("FAIL gap_res: got %h want 4300", res); end
    n_vec++; if (rdy !== 5) begin n_err++; $display("FAIL gap_ready_cycles: got %0d want 5", rdy); end
    nbub = 0;
    for (int c = 0; c < HIST - STOP_DLY; c++) begin
      if (slot_kind[c] >= 0) begin
        if (slot_kind[c] == 1) nbub++;
        n_vec++;
        if (stop_hist[c + STOP_DLY] !== 1'(slot_kind[c])) begin
          n_err++;
          $display("FAIL gap_mac_stop@%0d: got %b want %0d", c + STOP_DLY, stop_hist[c + STOP_DLY], slot_kind[c]);
        end
      end
    end
    n_vec++; if (nbub !== 3) begin n_err++; $display("FAIL gap_bubble_slots: got %0d want 3", nbub); end
  endtask

  task automatic test_zero_len();
    logic [15:0] va [0:3];
    logic [15:0] vb [0:3];
    logic [15:0] res;
    int lat, pulses, rdy;
    bit tmo;
    va = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    vb = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    run_vec(0, va, vb, 0, 1'b0, res, lat, pulses, rdy, tmo);
    n_vec++; if (rdy !== 0) begin n_err++; $display("FAIL zero_ready_cycles: got %0d want 0", rdy); end
    n_vec++; if (res !== 16'h0000) begin n_err++; $display("FAIL zero_res: got %h want 0000", res); end
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL zero_pulses: got %0d want 1", pulses); end
    n_vec++; if (host.busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_after: got %b want 0", host.busy); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] va [0:3];
    logic [15:0] vb [0:3];
    logic [15:0] res;
    int lat, pulses, rdy, cyc;
    bit tmo, got;
    host.start   = 1'b1;
    host.vec_len = 8'd2;
    tick();
    host.start    = 1'b0;
    host.in_valid = 1'b1;
    host.in_a     = 16'h3C00;
    host.in_b     = 16'h4000;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < MAX_CYC) begin
      got = host.in_ready;
      tick();
      cyc++;
    end
    host.in_valid = 1'b0;
    n_vec++; if (!got) begin n_err++; $display("FAIL mid_rst_timeout: got no in_ready want handshake"); end
    n_vec++; if (host.in_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_pre_ready: got %b want 1", host.in_ready); end
    rst = 1'b1;
    #1;
    n_vec++; if (host.busy !== 1'b0 || host.in_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_idle: got busy=%b ready=%b want 0/0", host.busy, host.in_ready); end
    n_vec++; if (mac_stop !== 1'b1) begin n_err++; $display("FAIL mid_rst_mac_stop: got %b want 1", mac_stop); end
    n_vec++; if (host.res_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_res_valid: got %b want 0", host.res_valid); end
    tick();
    rst = 1'b0;
    tick();
    va = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
    vb = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
    run_vec(1, va, vb, 0, 1'b0, res, lat, pulses, rdy, tmo);
    n_vec++; if (res !== 16'h4400) begin n_err++; $display("FAIL mid_rst_next_res: got %h want 4400", res); end
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL mid_rst_next_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_start_while_busy();
    logic [15:0] va [0:3];
    logic [15:0] vb [0:3];
    logic [15:0] res;
    int lat, pulses, rdy;
    bit tmo;
    va = '{16'h3C00, 16'h4200, 16'h0000, 16'h0000};
    vb = '{16'h4000, 16'h3800, 16'h0000, 16'h0000};
    run_vec(2, va, vb, 0, 1'b1, res, lat, pulses, rdy, tmo);
    n_vec++; if (res !== 16'h4300) begin n_err++; $display("FAIL busy_start_res: got %h want 4300", res); end
    n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL busy_start_pulses: got %0d want 1", pulses); end
    n_vec++; if (rdy !== 2) begin n_err++; $display("FAIL busy_start_ready_cycles: got %0d want 2", rdy); end
    n_vec++; if (host.busy !== 1'b0) begin n_err++; $display("FAIL busy_start_busy_after: got %b want 0", host.busy); end
  endtask

  initial begin
    rst           = 1'b1;
    host.start    = 1'b0;
    host.vec_len  = 8'd0;
    host.in_valid = 1'b0;
    host.in_a     = 16'h0000;
    host.in_b     = 16'h0000;
    test_reset();
    test_back_to_back();
    test_consecutive();
    test_gaps();
    test_zero_len();
    test_reset_mid();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp16_dot_sequencer.md
Name: fp16_dot_sequencer

Overview:
- Upstream control stage for the FP16 multiply-accumulate pipeline.
- Accepts a stream of FP16 operand pairs over a valid/ready handshake and drives the MAC's operand and stop inputs.
- The MAC accumulator has no reset, so the sequencer zeroes it before each vector by issuing one exact cancelling operation.
- After the pipeline drains, it captures the accumulator and presents one dot-product result per vector.

Parameters:
- LEN_W, 8: width of vector-length field; maximum vector length is 2^LEN_W-1.
- STOP_DLY, 2: cycles between operand issue and the point where the MAC applies stop to that operand's product.
- DRAIN_CYC, 4: cycles waited after the last issue before the accumulator is sampled.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a vector; sampled only in IDLE.
- vec_len  in  LEN_W  element count; latched on an accepted start.
- in_valid  in  1  operand pair present.
- in_ready  out  1  pair accepted this cycle when in_valid && in_ready.
- in_a  in  16  FP16 operand A.
- in_b  in  16  FP16 operand B.
- mac_num_a  out  16  registered operand A to the MAC.
- mac_num_b  out  16  registered operand B to the MAC.
- mac_stop  out  1  registered product-kill to the MAC.
- mac_acc  in  16  accumulator output from the MAC.
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  one-cycle pulse when res_data is updated.
- res_data  out  16  captured dot-product result; holds until the next capture.

Behaviour:
- Reset values:
  - state=IDLE
  - mac_num_a=mac_num_b=16'h0000
  - kill shift register all ones, so mac_stop=1
  - res_valid=0, res_data=16'h0000, busy=0, in_ready=0
  - counters 0
- Each cycle the sequencer drives an "issue slot" on mac_num_a/mac_num_b.
  - kill=0 for a real operand, kill=1 for a bubble; bubbles drive 16'h0000 on both operands.
  - kill enters a STOP_DLY-deep shift register; mac_stop is its output.
  - This delay is required because the MAC gates the product at the second pipeline register, not at its input.
- FSM states and transitions:
  - IDLE: start=1 → latch vec_len → FLUSH. Start while busy is ignored.
  - FLUSH: bubbles for DRAIN_CYC cycles so the accumulator is stable → CLR.
  - CLR: issue mac_num_a={~mac_acc[15],mac_acc[14:0]}, mac_num_b=16'h3C00 (1.0) with kill=0; acc + (-acc) = +0 exactly → CLR_DRAIN.
  - CLR_DRAIN: bubbles for DRAIN_CYC cycles. Then vec_len==0 → CAPTURE, else → ISSUE.
  - ISSUE: in_ready=1.
    - On handshake, issue the pair with kill=0 and decrement the remaining count.
    - in_valid=0 issues a bubble.
    - When the remaining count reaches 0 on a handshake → DRAIN, with in_ready=0 the following cycle.
  - DRAIN: bubbles for DRAIN_CYC cycles → CAPTURE.
  - CAPTURE: res_data<=mac_acc, res_valid=1 for one cycle → IDLE.
- Timing and throughput:
  - in_ready is combinational from state only and is 1 only in ISSUE.
  - Throughput is 1 pair/cycle.
  - Latency from last accepted pair to res_valid is DRAIN_CYC+1 cycles.
- Boundary conditions:
  - vec_len=0: the result is the cleared accumulator, 16'h0000.
  - A start pulse in the same cycle as CAPTURE is ignored.
  - rst mid-operation returns to IDLE immediately, discards in-flight work, and forces mac_stop=1; the next vector re-clears.
  - NaN/Inf in the accumulator: the clear step propagates NaN, which is documented and not corrected.
  - The count uses an LEN_W-bit down-counter with no wrap: ISSUE exits exactly at 0.

Decomposition:
- Shared package fp16_mac_pkg:
  - FP16 constants: FP16_ONE=16'h3C00, FP16_ZERO=16'h0000.
  - Sign-flip helper.
  - FSM state enum: IDLE, FLUSH, CLR, CLR_DRAIN, ISSUE, DRAIN, CAPTURE.
  - Default MAC pipeline latency.
- One sub-module, mac_kill_delay: a parameterised STOP_DLY shift register with async set-to-one reset.
- The FSM, counters and capture register stay in the top block.
- The bench instantiates the existing MAC with this block for integration tests.

Test Plan:
- vec_len=2, pairs (3C00,4000),(4200,3800) back-to-back → res_data=16'h4300 (3.5), res_valid one pulse, DRAIN_CYC+1 cycles after the last handshake.
- Two consecutive vectors, second vec_len=1 with (4000,4000) → second res_data=16'h4400 (4.0), proving the clear step.
- Same as the first scenario with in_valid low for 3 cycles between pairs → res_data=16'h4300; mac_stop high exactly STOP_DLY cycles after each bubble slot.
- vec_len=0 → no in_ready pulse, res_data=16'h0000, busy drops after CAPTURE.
- rst asserted during ISSUE after one pair → same-cycle IDLE, mac_stop=1, res_valid=0; a new vector (4000,4000) then yields 16'h4400.
- start pulsed while busy → ignored; exactly one res_valid for the original vector.
